// File: rtl/dp_cache_responder_pkg.sv
// ============================================================================
// Module      : dp_cache_responder_pkg
// Description : Shared types for the datapath cache responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dp_cache_responder_pkg;

    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;

    typedef logic [C_DATA_W-1:0] word_t;
    typedef logic [C_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        RESP
    } dcr_state_t;

    typedef enum logic [1:0] {
        OP_IREAD,
        OP_DREAD,
        OP_DWRITE
    } mem_op_t;

endpackage

`default_nettype wire

// File: rtl/dp_cache_responder_arbiter.sv
// ============================================================================
// Module      : dcr_arbiter
// Description : IDLE-state grant logic with a data-streak limiter that lets a
//               waiting instruction fetch in after MAX_D_STREAK data grants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcr_arbiter
    import dp_cache_responder_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       imemREN,
    input  logic       dmemREN,
    input  logic       dmemWEN,
    input  dcr_state_t state,
    output logic       grant_i,
    output logic       grant_d
);

    localparam int C_SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [C_SW-1:0] c_streak_max = C_SW'(MAX_D_STREAK);
    localparam logic [C_SW-1:0] c_one        = C_SW'(1);

    logic [C_SW-1:0] r_d_streak;
    logic            w_dreq;
    logic            w_i_forced;

    assign w_dreq     = dmemREN | dmemWEN;
    assign w_i_forced = imemREN && (r_d_streak == c_streak_max);

    assign grant_d = (state == IDLE) && w_dreq && !w_i_forced;
    assign grant_i = (state == IDLE) && imemREN && (!w_dreq || w_i_forced);

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_d_streak <= '0;
        end else if (grant_i) begin
            r_d_streak <= '0;
        end else if (grant_d) begin
            // Only data grants that actually starve a fetch count toward the limit.
            if (!imemREN)
                r_d_streak <= '0;
            else if (r_d_streak != c_streak_max)
                r_d_streak <= r_d_streak + c_one;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dp_cache_responder.sv
// ============================================================================
// Module      : dp_cache_responder
// Description : Serves datapath fetch and load/store requests over a single
//               ready-handshaked memory port, returning ihit/dhit pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_cache_responder
    import dp_cache_responder_pkg::*;
#(
    parameter int ADDR_W       = C_ADDR_W,
    parameter int DATA_W       = C_DATA_W,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] imemload,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dmemload,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    dcr_state_t r_state;
    mem_op_t    r_op;
    logic       w_grant_i;
    logic       w_grant_d;

    dcr_arbiter #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_arbiter (
        .CLK     (CLK),
        .rst     (rst),
        .imemREN (imemREN),
        .dmemREN (dmemREN),
        .dmemWEN (dmemWEN),
        .state   (r_state),
        .grant_i (w_grant_i),
        .grant_d (w_grant_d)
    );

    // A fetch is only acknowledged if the datapath still wants the same address.
    assign ihit = (r_state == RESP) && (r_op == OP_IREAD) && imemREN && (imemaddr == mem_addr);
    assign dhit = (r_state == RESP) && (r_op != OP_IREAD);

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_IREAD;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            imemload  <= '0;
            dmemload  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_op      <= dmemWEN ? OP_DWRITE : OP_DREAD;
                        mem_addr  <= dmemaddr;
                        mem_wdata <= dmemstore;
                        mem_wen   <= dmemWEN;
                        mem_ren   <= !dmemWEN;
                        r_state   <= DACC;
                    end else if (w_grant_i) begin
                        r_op      <= OP_IREAD;
                        mem_addr  <= imemaddr;
                        mem_ren   <= 1'b1;
                        r_state   <= IACC;
                    end
                end
                IACC: begin
                    if (mem_ready) begin
                        imemload <= mem_rdata;
                        mem_ren  <= 1'b0;
                        r_state  <= RESP;
                    end
                end
                DACC: begin
                    if (mem_ready) begin
                        if (r_op == OP_DREAD)
                            dmemload <= mem_rdata;
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dp_cache_responder.sv
// ============================================================================
// Module      : tb_dp_cache_responder
// Description : Directed self-checking bench for dp_cache_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dp_cache_responder;

    logic        CLK;
    logic        rst;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 0;
    int          wait_cnt = 0;
    logic [31:0] wr_addr  = '0;
    logic [31:0] wr_data  = '0;

    dp_cache_responder #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: ready after 'lat' cycles of a held strobe.
    assign mem_ready = (mem_ren | mem_wen) && (wait_cnt >= lat);
    assign mem_rdata = (mem_ren && mem_ready) ? mem_word(mem_addr) : 32'h0;

    always @(posedge CLK) begin
        if (!(mem_ren | mem_wen) || mem_ready) wait_cnt <= 0;
        else                                   wait_cnt <= wait_cnt + 1;
        if (mem_wen && mem_ready) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs n cycles, dropping each request on its hit, and tallies activity.
    task automatic run_cycles(input int n, output int ren_c, output int wen_c,
                              output int dh_c, output int ih_c, output int first_hit,
                              output logic [31:0] first_addr, output logic [31:0] first_wdata);
        ren_c = 0; wen_c = 0; dh_c = 0; ih_c = 0; first_hit = 0;
        first_addr = 32'hFFFF_FFFF; first_wdata = 32'hFFFF_FFFF;
        for (int i = 1; i <= n; i++) begin
            step();
            if ((mem_ren | mem_wen) && (ren_c + wen_c == 0)) begin
                first_addr  = mem_addr;
                first_wdata = mem_wdata;
            end
            if (mem_ren) ren_c++;
            if (mem_wen) wen_c++;
            if (dhit) begin
                dh_c++;
                if (first_hit == 0) first_hit = i;
                dmemREN = 1'b0;
                dmemWEN = 1'b0;
            end
            if (ihit) begin
                ih_c++;
                if (first_hit == 0) first_hit = i;
                imemREN = 1'b0;
            end
        end
    endtask

    int          rc, wc, dc, ic, fh, nh, bad;
    logic [31:0] fa, fw;
    logic [9:0]  seq;

    initial begin
        rst = 1'b1; imemREN = 1'b0; imemaddr = '0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        repeat (2) step();
        check("rst_ihit",     ihit,      0);
        check("rst_dhit",     dhit,      0);
        check("rst_strobes",  {mem_ren, mem_wen}, 0);
        check("rst_mem_addr", mem_addr,  0);
        check("rst_wdata",    mem_wdata, 0);
        check("rst_loads",    {imemload, dmemload}, 0);
        rst = 1'b0;
        step();

        // Single load, ready after 2 cycles
        lat = 2; dmemREN = 1'b1; dmemaddr = 32'h100;
        run_cycles(10, rc, wc, dc, ic, fh, fa, fw);
        check("ld_addr",    fa, 32'h100);
        check("ld_ren_cyc", rc, 3);
        check("ld_wen_cyc", wc, 0);
        check("ld_dhits",   dc, 1);
        check("ld_latency", fh, 4);
        check("ld_data",    dmemload, 32'hDEADBEEF);

        // Store, immediate ready
        lat = 0; dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'h12345678;
        run_cycles(8, rc, wc, dc, ic, fh, fa, fw);
        check("st_wdata",   fw, 32'h12345678);
        check("st_wen_cyc", wc, 1);
        check("st_ren_cyc", rc, 0);
        check("st_dhits",   dc, 1);
        check("st_latency", fh, 2);
        check("st_mem_wr",  {wr_addr, wr_data}, {32'h200, 32'h12345678});

        // Both strobes: must be a write
        lat = 1; dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h300; dmemstore = 32'hCAFEF00D;
        run_cycles(8, rc, wc, dc, ic, fh, fa, fw);
        check("both_ren_cyc", rc, 0);
        check("both_wen_cyc", wc, 2);
        check("both_dhits",   dc, 1);
        check("both_mem_wr",  {wr_addr, wr_data}, {32'h300, 32'hCAFEF00D});

        // Contention: expect D D D D I repeating
        lat = 0; imemREN = 1'b1; imemaddr = 32'h10; dmemREN = 1'b1; dmemaddr = 32'h104;
        seq = '0; nh = 0;
        for (int i = 0; i < 60 && nh < 10; i++) begin
            step();
            if (dhit) begin seq = {seq[8:0], 1'b0}; nh++; end
            if (ihit) begin seq = {seq[8:0], 1'b1}; nh++; end
        end
        imemREN = 1'b0; dmemREN = 1'b0;
        check("cont_hits",  nh, 10);
        check("cont_order", seq, 10'b0000100001);
        check("cont_iload", imemload, mem_word(32'h10));
        check("cont_dload", dmemload, mem_word(32'h104));
        repeat (3) step();

        // Redirect mid-fetch
        lat = 3; imemREN = 1'b1; imemaddr = 32'h40;
        step();
        check("rd_first_ren",  mem_ren, 1);
        check("rd_first_addr", mem_addr, 32'h40);
        imemaddr = 32'h80;
        ic = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ihit) begin
                ic++;
                if (mem_addr == 32'h40) bad++;
                imemREN = 1'b0;
            end
        end
        check("rd_ihits",    ic, 1);
        check("rd_stale_hit", bad, 0);
        check("rd_iload",    imemload, mem_word(32'h80));

        // Reset during a data access
        lat = 10; dmemREN = 1'b1; dmemaddr = 32'h500;
        step(); step();
        check("rm_ren_before", mem_ren, 1);
        rst = 1'b1; dmemREN = 1'b0;
        step();
        check("rm_strobes", {mem_ren, mem_wen}, 0);
        check("rm_hits",    {ihit, dhit}, 0);
        check("rm_regs",    {mem_addr, mem_wdata}, 0);
        check("rm_loads",   {imemload, dmemload}, 0);
        rst = 1'b0;
        run_cycles(10, rc, wc, dc, ic, fh, fa, fw);
        check("rm_no_dhit", dc, 0);
        check("rm_idle",    rc + wc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
